board_reader: RTL

Read-side companion to the board setup path. It walks a user-selected row index over the 16x16 cell board using debounced up/down buttons. It fetches that row from board storage over a request/acknowledge read port and drives the 16 row cells onto the LEDs. The row is re-fetched periodically, so the display tracks the board while generations evolve. It sits between the board storage and the board-level LED/button pins.

---
 rtl/board_reader.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/board_reader.sv
// board_reader
//   Selects a row of the 16x16 cell board with debounced up/down buttons.
//   The selected row is fetched from board storage over a req/ack read port
//   and shown on the LEDs. The row is re-fetched periodically so the display
//   follows the evolving board.
//
// Optional feature macro: BOARD_READER_AUTOSCAN_EN
//   When defined, a free-running scan counter steps row_index every
//   SCAN_CYCLES cycles while enabled, wrapping from 15 to 0.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   enable     block active; gates buttons and new reads
//   BtnU       raw button, decrements the row (saturates at 0)
//   BtnD       raw button, increments the row (saturates at 15)
//   rd_req     read request to board storage
//   rd_row     row address, stable while rd_req is high
//   rd_ack     storage acknowledge, rd_data valid in the same cycle
//   rd_data    row cells, bit i is column i
//   Led        last fetched row
//   row_index  currently selected row
//   busy       high while the FSM is in REQ or DONE
module board_reader #(
  parameter int DB_COUNT       = 50000,
  parameter int REFRESH_CYCLES = 1000000
`ifdef BOARD_READER_AUTOSCAN_EN
  ,
  parameter int SCAN_CYCLES    = 50000000
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        BtnU,
  input  logic        BtnD,
  output logic        rd_req,
  output logic [3:0]  rd_row,
  input  logic        rd_ack,
  input  logic [15:0] rd_data,
  output logic [15:0] Led,
  output logic [3:0]  row_index,
  output logic        busy
);

  localparam int DB_W = $clog2(DB_COUNT + 1);
  localparam int RF_W = $clog2(REFRESH_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Button conditioning: index 0 is up, index 1 is down.
  logic [1:0]      btn_s;
  logic [1:0]      sync1_r;
  logic [1:0]      sync2_r;
  logic [1:0]      db_lvl_r;
  logic [1:0]      db_prev_r;
  logic [DB_W-1:0] db_cnt_r [2];
  logic [1:0]      press_s;
  logic            up_s;
  logic            dn_s;

  // Row selection and read triggers.
  logic [3:0]      row_index_r;
  logic [3:0]      row_next_s;
  logic            row_change_s;
  logic            enable_d_r;
  logic            en_rise_s;
  logic            refresh_hit_s;
  logic            trig_s;
  logic            scan_step_s;

  // Read FSM.
  state_t          state_r;
  logic            pending_r;
  logic [RF_W-1:0] refresh_cnt_r;
  logic            rd_req_r;
  logic [3:0]      rd_row_r;
  logic [15:0]     data_r;
  logic [15:0]     led_r;
  logic            busy_r;

  assign btn_s = {BtnD, BtnU};

  // Two-flop synchronizer, debounce counter and edge history per button.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r   <= 2'b00;
      sync2_r   <= 2'b00;
      db_lvl_r  <= 2'b00;
      db_prev_r <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        db_cnt_r[i] <= '0;
      end
    end else begin
      sync1_r   <= btn_s;
      sync2_r   <= sync1_r;
      db_prev_r <= db_lvl_r;
      for (int i = 0; i < 2; i++) begin
        // Any cycle where the input agrees with the accepted level restarts the count.
        if (sync2_r[i] != db_lvl_r[i]) begin
          if (db_cnt_r[i] == DB_W'(DB_COUNT - 1)) begin
            db_lvl_r[i] <= sync2_r[i];
            db_cnt_r[i] <= '0;
          end else begin
            db_cnt_r[i] <= db_cnt_r[i] + DB_W'(1);
          end
        end else begin
          db_cnt_r[i] <= '0;
        end
      end
    end
  end

  assign press_s = db_lvl_r & ~db_prev_r;
  assign up_s    = press_s[0] & enable;
  assign dn_s    = press_s[1] & enable;

`ifdef BOARD_READER_AUTOSCAN_EN
  localparam int SC_W = $clog2(SCAN_CYCLES + 1);
  logic [SC_W-1:0] scan_cnt_r;

  // A press takes priority over a scan step in the same cycle.
  assign scan_step_s = enable && !(up_s || dn_s) &&
                       (scan_cnt_r == SC_W'(SCAN_CYCLES - 1));

  // Free-running scan counter; a button press restarts the scan period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_r <= '0;
    end else if (up_s || dn_s) begin
      scan_cnt_r <= '0;
    end else if (enable) begin
      if (scan_cnt_r == SC_W'(SCAN_CYCLES - 1)) begin
        scan_cnt_r <= '0;
      end else begin
        scan_cnt_r <= scan_cnt_r + SC_W'(1);
      end
    end else begin
      scan_cnt_r <= scan_cnt_r;
    end
  end
`else
  // Without autoscan the row only moves on button presses.
  assign scan_step_s = 1'b0;
`endif

  // Next row: saturating button moves, cancelling simultaneous presses, wrapping scan steps.
  always_comb begin
    row_next_s = row_index_r;
    if (up_s && !dn_s) begin
      if (row_index_r != 4'd0) begin
        row_next_s = row_index_r - 4'd1;
      end else begin
        row_next_s = row_index_r;
      end
    end else if (dn_s && !up_s) begin
      if (row_index_r != 4'd15) begin
        row_next_s = row_index_r + 4'd1;
      end else begin
        row_next_s = row_index_r;
      end
    end else if (scan_step_s) begin
      row_next_s = row_index_r + 4'd1;
    end else begin
      row_next_s = row_index_r;
    end
  end

  assign row_change_s  = (row_next_s != row_index_r);
  assign en_rise_s     = enable & ~enable_d_r;
  assign refresh_hit_s = (state_r == ST_IDLE) && enable &&
                         (refresh_cnt_r == RF_W'(REFRESH_CYCLES - 1));
  assign trig_s        = row_change_s | refresh_hit_s | en_rise_s;

  // Selected row and enable history (enable_d_r starts low so the first enabled cycle triggers).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_index_r <= 4'd0;
      enable_d_r  <= 1'b0;
    end else begin
      row_index_r <= row_next_s;
      enable_d_r  <= enable;
    end
  end

  // Read FSM with registered handshake outputs, pending flag and refresh timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      pending_r     <= 1'b0;
      refresh_cnt_r <= '0;
      rd_req_r      <= 1'b0;
      rd_row_r      <= 4'd0;
      data_r        <= 16'h0000;
      led_r         <= 16'h0000;
      busy_r        <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          // A trigger seen this cycle starts the read at once; row_next_s is the newest row.
          if (enable && (pending_r || trig_s)) begin
            state_r       <= ST_REQ;
            rd_row_r      <= row_next_s;
            pending_r     <= 1'b0;
            refresh_cnt_r <= '0;
            rd_req_r      <= 1'b1;
            busy_r        <= 1'b1;
          end else begin
            state_r   <= ST_IDLE;
            pending_r <= pending_r | trig_s;
            rd_req_r  <= 1'b0;
            busy_r    <= 1'b0;
            if (enable) begin
              refresh_cnt_r <= refresh_cnt_r + RF_W'(1);
            end else begin
              refresh_cnt_r <= refresh_cnt_r;
            end
          end
        end
        ST_REQ: begin
          pending_r <= pending_r | trig_s;
          busy_r    <= 1'b1;
          if (rd_ack) begin
            data_r   <= rd_data;
            state_r  <= ST_DONE;
            rd_req_r <= 1'b0;
          end else begin
            state_r  <= ST_REQ;
            rd_req_r <= 1'b1;
          end
        end
        ST_DONE: begin
          pending_r <= pending_r | trig_s;
          led_r     <= data_r;
          state_r   <= ST_IDLE;
          rd_req_r  <= 1'b0;
          busy_r    <= 1'b0;
        end
        default: begin
          state_r   <= ST_IDLE;
          pending_r <= 1'b0;
          rd_req_r  <= 1'b0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  assign rd_req    = rd_req_r;
  assign rd_row    = rd_row_r;
  assign Led       = led_r;
  assign row_index = row_index_r;
  assign busy      = busy_r;

endmodule
